// File: rtl/mem_scan_pkg.sv
// Shared sizing constants and controller state type for the 32x3 RAM scanner.
package mem_scan_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 32;
    localparam int SUM_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_scanner.sv
// Walks a 32x3 registered-input RAM once, either filling it with a seeded
// pattern or reading every word back and accumulating a checksum.
module mem_scanner
    import mem_scan_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_seed,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [SUM_W-1:0]  sum,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        rd_valid_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        sum_d       = sum_q;
        next_addr   = mem_addr_q + 1'b1;

        // pend_q marks the cycle where mem_dout reflects the address issued last cycle
        if (pend_q) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = pend_addr_q;
            rd_data_d  = mem_dout;
            sum_d      = sum_q + SUM_W'(mem_dout);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = mode ? FILL : SCAN;
                    seed_d      = fill_seed;
                    mem_addr_d  = '0;
                    mem_write_d = mode;
                    sum_d       = '0;
                    if (mode) begin
                        mem_din_d = fill_seed;
                    end
                end
            end
            FILL, SCAN: begin
                pend_d      = (state_q == SCAN);
                pend_addr_d = mem_addr_q;
                if (mem_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    mem_addr_d = next_addr;
                    if (state_q == FILL) begin
                        mem_write_d = 1'b1;
                        mem_din_d   = seed_q + next_addr[DATA_W-1:0];
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            sum_q       <= sum_d;
        end
    end

    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign sum       = sum_q;
    assign busy      = (state_q == FILL) || (state_q == SCAN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_scanner.sv
// Directed bench for mem_scanner with a registered-input 32x3 RAM model beside it.
module tb_mem_scanner;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [2:0] fill_seed;
    logic       mem_write;
    logic [4:0] mem_addr;
    logic [2:0] mem_din;
    logic [2:0] mem_dout;
    logic       rd_valid;
    logic [4:0] rd_addr;
    logic [2:0] rd_data;
    logic [7:0] sum;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    mem_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .fill_seed (fill_seed),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .sum       (sum),
        .busy      (busy),
        .done      (done)
    );

    // RAM: inputs registered on the rising edge, read data combinational from the registered address
    logic [2:0] ram [32];
    logic [4:0] ram_addr_r;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 3'd0;
        ram_addr_r = 5'd0;
    end

    always @(posedge clk) begin
        ram_addr_r <= mem_addr;
        if (mem_write) ram[mem_addr] <= mem_din;
    end

    assign mem_dout = ram[ram_addr_r];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_din"},   mem_din,   0);
        check({tag, "_rd_valid"},  rd_valid,  0);
        check({tag, "_rd_addr"},   rd_addr,   0);
        check({tag, "_rd_data"},   rd_data,   0);
        check({tag, "_sum"},       sum,       0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle; walks cycles 0..33 of one operation.
    task automatic do_op(input logic m, input logic [2:0] seed, input logic [2:0] exp_seed,
                         input int pulse_at, input logic hold);
        int         n_wr;
        logic [7:0] exp_sum;
        logic [7:0] ent;
        logic [2:0] dat;
        n_wr    = 0;
        exp_sum = 8'd0;
        exp_q.delete();
        if (!m) begin
            for (int a = 0; a < 32; a++) begin
                dat = exp_seed + 3'(a);
                exp_q.push_back({5'(a), dat});
            end
        end
        start     = 1'b1;
        mode      = m;
        fill_seed = seed;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 0; c < 34; c++) begin
            check("busy", busy, c <= 32);
            check("done", done, c == 33);
            check("mem_write", mem_write, m && (c <= 31));
            check("mem_addr", mem_addr, (c <= 31) ? c : 31);
            if (m && c <= 31) begin
                dat = seed + 3'(c);
                check("mem_din", mem_din, dat);
            end
            if (mem_write) n_wr++;
            check("rd_valid", rd_valid, !m && (c >= 2));
            if (!m && c >= 2) begin
                dat     = exp_seed + 3'(c - 2);
                exp_sum = exp_sum + {5'b0, dat};
            end
            check("sum", sum, exp_sum);
            if (rd_valid) begin
                check("rd_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ent = exp_q.pop_front();
                    check("rd_addr", rd_addr, ent[7:3]);
                    check("rd_data", rd_data, ent[2:0]);
                end
                if (exp_seed == 3'd0 && rd_addr[2:0] == 3'd7) check("rd_data_a7", rd_data, 7);
            end
            if (c == 33 && !m) check("sum_final", sum, 112);
            if (!hold) start = (c == pulse_at);
            @(posedge clk); #1;
        end
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rd_valid", rd_valid, 0);
        check("sum_hold", sum, exp_sum);
        if (m) check("fill_writes", n_wr, 32);
        else   check("rd_left", exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        fill_seed = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Seed 3 fill, then scan back with full timing checks
        do_op(1'b1, 3'd3, 3'd0, -1, 1'b0);
        do_op(1'b0, 3'd0, 3'd3, -1, 1'b0);

        // Seed 0 fill; scan with a stray start pulse in cycle 10
        do_op(1'b1, 3'd0, 3'd0, -1, 1'b0);
        do_op(1'b0, 3'd0, 3'd0, 10, 1'b0);

        // Abort a seed-7 fill in cycle 5
        start     = 1'b1;
        mode      = 1'b1;
        fill_seed = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort_pre_addr", mem_addr, 5);
        check("abort_pre_write", mem_write, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("abort");
        @(posedge clk); #1;
        check("abort_stays_idle", busy, 0);

        // reset wins over start on the same edge
        start = 1'b1;
        mode  = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        check("prio_busy", busy, 0);
        check("prio_mem_write", mem_write, 0);
        @(posedge clk); #1;
        check("prio_still_idle", busy, 0);

        do_op(1'b1, 3'd5, 3'd0, -1, 1'b0);
        do_op(1'b0, 3'd0, 3'd5, -1, 1'b0);

        // start held high: two scans back to back
        do_op(1'b0, 3'd0, 3'd5, -1, 1'b1);
        do_op(1'b0, 3'd0, 3'd5, -1, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
